// File: rtl/mem_ctrl_bridge.sv
// Word-to-byte memory bridge: serializes one CPU word request into B byte beats on the RAM side.
// Define MEM_CTRL_BIG_ENDIAN_EN to map beat i to byte B-1-i (default: little-endian).
module mem_ctrl_bridge #(
    parameter int MADDR_L  = 32,
    parameter int M_DATA_L = 8,
    parameter int C_DATA_L = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [M_DATA_L-1:0] m_dout,
    output logic [M_DATA_L-1:0] m_din,
    output logic [MADDR_L-1:0]  m_raddr,
    output logic [MADDR_L-1:0]  m_waddr,
    output logic                m_re,
    output logic                m_we,
    input  logic [C_DATA_L-1:0] c_dout,
    output logic [C_DATA_L-1:0] c_din,
    input  logic [MADDR_L-1:0]  c_raddr,
    input  logic [MADDR_L-1:0]  c_waddr,
    input  logic                c_re,
    input  logic                c_we
);
    localparam int B  = C_DATA_L / M_DATA_L;
    localparam int IW = (B > 1) ? $clog2(B) : 1;
    localparam logic [IW-1:0] LAST = IW'(B - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         i_q, i_d;
    logic [MADDR_L-1:0]    addr_q, addr_d;
    logic [C_DATA_L-1:0]   wdata_q, wdata_d;
    logic [C_DATA_L-1:0]   asm_q, asm_d;
    logic [C_DATA_L-1:0]   c_din_q, c_din_d;
    logic [M_DATA_L-1:0]   m_din_q, m_din_d;
    logic [MADDR_L-1:0]    m_raddr_q, m_raddr_d;
    logic [MADDR_L-1:0]    m_waddr_q, m_waddr_d;
    logic                  m_re_q, m_re_d;
    logic                  m_we_q, m_we_d;
    logic                  cap_vld_q, cap_vld_d;
    logic [IW-1:0]         cap_idx_q, cap_idx_d;

    function automatic logic [IW-1:0] lane(input logic [IW-1:0] beat);
`ifdef MEM_CTRL_BIG_ENDIAN_EN
        return LAST - beat;
`else
        return beat;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            asm_q     <= '0;
            c_din_q   <= '0;
            m_din_q   <= '0;
            m_raddr_q <= '0;
            m_waddr_q <= '0;
            m_re_q    <= 1'b0;
            m_we_q    <= 1'b0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            asm_q     <= asm_d;
            c_din_q   <= c_din_d;
            m_din_q   <= m_din_d;
            m_raddr_q <= m_raddr_d;
            m_waddr_q <= m_waddr_d;
            m_re_q    <= m_re_d;
            m_we_q    <= m_we_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        asm_d     = asm_q;
        c_din_d   = c_din_q;
        m_din_d   = m_din_q;
        m_raddr_d = m_raddr_q;
        m_waddr_d = m_waddr_q;
        m_re_d    = 1'b0;
        m_we_d    = 1'b0;
        cap_vld_d = 1'b0;
        cap_idx_d = cap_idx_q;

        // RAM data arrives the cycle after a beat is issued; the last capture may land in IDLE,
        // which lets the FSM be free for a new request on the same edge.
        if (cap_vld_q) begin
            asm_d[lane(cap_idx_q)*M_DATA_L +: M_DATA_L] = m_dout;
            if (cap_idx_q == LAST)
                c_din_d = asm_d;
        end

        case (state_q)
            IDLE: begin
                if (c_we) begin
                    addr_d  = c_waddr;
                    wdata_d = c_dout;
                    i_d     = '0;
                    state_d = WRITE;
                end else if (c_re) begin
                    addr_d  = c_raddr;
                    i_d     = '0;
                    state_d = READ;
                end
            end
            WRITE: begin
                m_we_d    = 1'b1;
                m_waddr_d = addr_q + MADDR_L'(i_q);
                m_din_d   = wdata_q[lane(i_q)*M_DATA_L +: M_DATA_L];
                i_d       = i_q + IW'(1);
                if (i_q == LAST) begin
                    i_d     = '0;
                    state_d = IDLE;
                end
            end
            READ: begin
                m_re_d    = 1'b1;
                m_raddr_d = addr_q + MADDR_L'(i_q);
                cap_vld_d = 1'b1;
                cap_idx_d = i_q;
                i_d       = i_q + IW'(1);
                if (i_q == LAST) begin
                    i_d     = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_din   = m_din_q;
    assign m_raddr = m_raddr_q;
    assign m_waddr = m_waddr_q;
    assign m_re    = m_re_q;
    assign m_we    = m_we_q;
    assign c_din   = c_din_q;
endmodule

// File: tb/tb_mem_ctrl_bridge.sv
// Directed + randomized bench for mem_ctrl_bridge with a byte-addressed reference memory model.
module tb_mem_ctrl_bridge;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  m_dout, m_din;
    logic [31:0] m_raddr, m_waddr;
    logic        m_re, m_we;
    logic [31:0] c_dout, c_din, c_raddr, c_waddr;
    logic        c_re, c_we;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram [0:1023];
    logic [7:0]  model [logic [31:0]];
    logic [31:0] last_exp = 32'h0;

    mem_ctrl_bridge #(.MADDR_L(32), .M_DATA_L(8), .C_DATA_L(32)) dut (
        .clk(clk), .rst(rst),
        .m_dout(m_dout), .m_din(m_din), .m_raddr(m_raddr), .m_waddr(m_waddr),
        .m_re(m_re), .m_we(m_we),
        .c_dout(c_dout), .c_din(c_din), .c_raddr(c_raddr), .c_waddr(c_waddr),
        .c_re(c_re), .c_we(c_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (m_we) ram[m_waddr[9:0]] <= m_din;
    assign m_dout = ram[m_raddr[9:0]];

    function automatic int shift_of(input int k);
`ifdef MEM_CTRL_BIG_ENDIAN_EN
        return 8 * (B - 1 - k);
`else
        return 8 * k;
`endif
    endfunction

    function automatic logic [7:0] wbyte(input logic [31:0] d, input int k);
        return 8'((d >> shift_of(k)) & 32'hFF);
    endfunction

    function automatic logic [7:0] mrd(input logic [31:0] a);
        return model.exists(a) ? model[a] : 8'h00;
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] a);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < B; k++) w = w | (32'(mrd(a + 32'(k))) << shift_of(k));
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input bit also_re, input bit busy_re);
        @(negedge clk);
        c_we = 1'b1; c_waddr = a; c_dout = d; c_re = also_re; c_raddr = a;
        for (int k = 0; k <= B; k++) begin
            @(negedge clk);
            c_we = 1'b0;
            c_re = busy_re && (k == 1);
            chk("wr_no_re", m_re, 0);
            if (k == 0) chk("wr_we_idle", m_we, 0);
            else begin
                chk("wr_we", m_we, 1);
                chk("wr_addr", m_waddr, a + 32'(k - 1));
                chk("wr_data", m_din, wbyte(d, k - 1));
            end
        end
        @(negedge clk);
        chk("wr_we_done", m_we, 0);
        chk("wr_no_re_done", m_re, 0);
        for (int k = 0; k < B; k++) model[a + 32'(k)] = wbyte(d, k);
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [31:0] exp = mword(a);
        @(negedge clk);
        c_re = 1'b1; c_raddr = a;
        for (int k = 0; k <= B; k++) begin
            @(negedge clk);
            c_re = 1'b0;
            chk("rd_hold", c_din, last_exp);
            chk("rd_no_we", m_we, 0);
            if (k == 0) chk("rd_re_idle", m_re, 0);
            else begin
                chk("rd_re", m_re, 1);
                chk("rd_addr", m_raddr, a + 32'(k - 1));
            end
        end
        @(negedge clk);
        chk("rd_data", c_din, exp);
        chk("rd_re_done", m_re, 0);
        last_exp = exp;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [31:0] waddrs [$];
        for (int k = 0; k < 1024; k++) ram[k] = 8'h00;
        rst = 1'b1; c_re = 1'b1; c_we = 1'b1;
        c_dout = 32'hCAFEF00D; c_raddr = 32'h10; c_waddr = 32'h20;

        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_m_din", m_din, 0);
            chk("rst_m_raddr", m_raddr, 0);
            chk("rst_m_waddr", m_waddr, 0);
            chk("rst_m_re", m_re, 0);
            chk("rst_m_we", m_we, 0);
            chk("rst_c_din", c_din, 0);
        end
        rst = 1'b0; c_re = 1'b0; c_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_re", m_re, 0);
            chk("post_rst_we", m_we, 0);
        end

        do_write(32'h100, 32'hDEADBEEF, 0, 0);
        do_read(32'h100);
        chk("readback_const", last_exp, 32'hDEADBEEF);

        do_write(32'hFFFFFFFE, 32'h11223344, 0, 0);
        do_read(32'hFFFFFFFE);

        do_write(32'h104, $urandom, 0, 1);
        do_write(32'h108, $urandom, 1, 0);
        do_read(32'h104);
        do_read(32'h108);

        // Abort a write after two beats have reached the RAM.
        d = 32'hA1B2C3D4;
        @(negedge clk);
        c_we = 1'b1; c_waddr = 32'h180; c_dout = d;
        @(negedge clk); c_we = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("abort_we", m_we, 0);
        chk("abort_waddr", m_waddr, 0);
        chk("abort_c_din", c_din, 0);
        rst = 1'b0;
        last_exp = 32'h0;
        model[32'h180] = wbyte(d, 0);
        model[32'h181] = wbyte(d, 1);
        @(negedge clk);
        chk("abort_we_after", m_we, 0);
        do_read(32'h180);

        for (int n = 0; n < 8; n++) begin
            a = 32'h200 + 32'($urandom_range(0, 32'h1F0));
            d = $urandom;
            do_write(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            waddrs.push_back(a);
            do_read(waddrs[$urandom_range(0, waddrs.size() - 1)]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
